// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//
// Serial pattern detector wrapped in a start/busy/done control FSM. A start in
// IDLE loads a parallel word, which is then shifted out MSB first, one bit per
// clock, into a PLEN-bit window. Each time the window equals the latched
// pattern (with at least PLEN valid bits in it), z pulses for one cycle and
// match_count increments (saturating at 31).
//
// Parameters
//   WIDTH  parallel data word width in bits (default 16)
//   PLEN   pattern length in bits (default 4, must be >= 2)
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   scan request, sampled only in IDLE
//   data_in      in   [WIDTH-1:0] word to scan, MSB consumed first
//   len          in   [4:0] number of bits to scan, clamped to WIDTH
//   pattern      in   [PLEN-1:0] pattern, pattern[PLEN-1] is the oldest bit
//   busy         out  high in LOAD and SHIFT
//   done         out  one-cycle pulse in DONE
//   z            out  registered one-cycle pulse per match
//   match_count  out  [4:0] matches in the current or last scan
//
// Build option
//   SEQ_DET_CTRL_OVERLAP_EN  when defined, overlapping matches are counted
//                            (window and fill untouched by a match). When
//                            undefined, a match empties the fill counter so
//                            the next match needs PLEN fresh bits.
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
    parameter int WIDTH = 16,
    parameter int PLEN  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       len,
    input  logic [PLEN-1:0]  pattern,
    output logic             busy,
    output logic             done,
    output logic             z,
    output logic [4:0]       match_count
);

    localparam int FW = $clog2(PLEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Scan operands captured in LOAD; they carry no reset since nothing
    // observes them outside a scan that LOAD has already initialised.
    logic [WIDTH-1:0] data_q, data_d;
    logic [PLEN-1:0]  pat_q,  pat_d;
    logic [4:0]       len_q,  len_d;

    logic [PLEN-1:0]  win_q,  win_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [4:0]       cnt_q,  cnt_d;
    logic [4:0]       mc_q,   mc_d;
    logic             z_q,    z_d;

    logic             shift_bit;
    logic             last_bit;

    // cnt_q counts bits already consumed, so the bit being consumed now is
    // the last one when cnt_q + 1 reaches the latched length.
    assign last_bit = ((cnt_q + 5'd1) == len_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            // Clamping to WIDTH never turns a non-zero len into zero.
            LOAD:    state_d = (len == 5'd0) ? DONE : SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == LOAD) || (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign z           = z_q;
    assign match_count = mc_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        data_d    = data_q;
        pat_d     = pat_q;
        len_d     = len_q;
        win_d     = win_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        mc_d      = mc_q;
        z_d       = 1'b0;
        shift_bit = data_q[WIDTH-1];

        case (state_q)
            LOAD: begin
                data_d = data_in;
                pat_d  = pattern;
                len_d  = (int'(len) > WIDTH) ? 5'(WIDTH) : len;
                win_d  = '0;
                fill_d = '0;
                cnt_d  = '0;
                mc_d   = '0;
            end
            SHIFT: begin
                data_d = data_q << 1;
                win_d  = {win_q[PLEN-2:0], shift_bit};
                fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
                cnt_d  = cnt_q + 5'd1;
                // Match is judged on the window and fill as they will be
                // after this bit, so z lands in the following cycle.
                if ((win_d == pat_q) && (fill_d == FILL_FULL)) begin
                    z_d  = 1'b1;
                    mc_d = (mc_q == 5'd31) ? mc_q : mc_q + 5'd1;
`ifdef SEQ_DET_CTRL_OVERLAP_EN
                    fill_d = fill_d;
`else
                    fill_d = '0;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            mc_q   <= '0;
            z_q    <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            mc_q   <= mc_d;
            z_q    <= z_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        pat_q  <= pat_d;
        len_q  <= len_d;
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
//
// Self-checking bench for seq_det_ctrl (WIDTH=16, PLEN=4). Expected behaviour
// comes from a reference model that finds pattern occurrences directly in the
// scanned bit string, then maps each occurrence to the cycle its z pulse is
// due. Honours SEQ_DET_CTRL_OVERLAP_EN like the design.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

    localparam int WIDTH = 16;
    localparam int PLEN  = 4;
`ifdef SEQ_DET_CTRL_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [4:0]       len;
    logic [PLEN-1:0]  pattern;
    logic             busy;
    logic             done;
    logic             z;
    logic [4:0]       match_count;

    int checks;
    int errors;
    int prev_mc;

    seq_det_ctrl #(.WIDTH(WIDTH), .PLEN(PLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .len         (len),
        .pattern     (pattern),
        .busy        (busy),
        .done        (done),
        .z           (z),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit k (1-based position in the scan) set when a pattern occurrence ends
    // at scanned bit k. Non-overlapping mode only accepts an occurrence that
    // shares no bits with the previously accepted one.
    function automatic logic [31:0] model_hits(input logic [15:0] d, input int eff,
                                               input logic [3:0] p);
        int last;
        logic [15:0] seg;
        logic [31:0] h;
        last = 0;
        h = '0;
        for (int k = 1; k <= eff; k++) begin
            if (k >= PLEN) begin
                seg = d >> (WIDTH - k);
                if ((seg[3:0] == p) && (OVERLAP || (k - last >= PLEN))) begin
                    h[k] = 1'b1;
                    last = k;
                end
            end
        end
        return h;
    endfunction

    function automatic int hits_upto(input logic [31:0] h, input int upto);
        int n;
        n = 0;
        for (int k = 1; k <= upto; k++) if (h[k]) n++;
        return (n > 31) ? 31 : n;
    endfunction

    // One complete scan with per-cycle checks of busy, done, z, match_count.
    // j counts rising edges after the edge that samples start.
    task automatic run_scan(input logic [15:0] d, input logic [4:0] l, input logic [3:0] p,
                            input bit poke_start, input int exp_cnt, input string name);
        int eff;
        logic [31:0] h;
        bit busy_e, done_e, z_e;
        int mc_e;
        eff = (int'(l) > WIDTH) ? WIDTH : int'(l);
        h = model_hits(d, eff, p);

        @(negedge clk);
        start = 1'b1; data_in = d; len = l; pattern = p;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || z !== 1'b0 || match_count !== 5'(prev_mc)) begin
            errors++;
            $display("FAIL %s load: busy/done/z/mc got %b/%b/%b/%0d exp 1/0/0/%0d",
                     name, busy, done, z, match_count, prev_mc);
        end

        for (int j = 1; j <= eff + 2; j++) begin
            @(posedge clk); #1;
            busy_e = (j <= eff);
            done_e = (j == eff + 1);
            z_e    = (j >= 2) && (j - 1 <= eff) && h[j-1];
            mc_e   = hits_upto(h, (j - 1 > eff) ? eff : j - 1);
            checks++;
            if (busy !== busy_e) begin
                errors++;
                $display("FAIL %s busy cyc%0d got %b exp %b", name, j, busy, busy_e);
            end
            checks++;
            if (done !== done_e) begin
                errors++;
                $display("FAIL %s done cyc%0d got %b exp %b", name, j, done, done_e);
            end
            checks++;
            if (z !== z_e) begin
                errors++;
                $display("FAIL %s z cyc%0d got %b exp %b", name, j, z, z_e);
            end
            checks++;
            if (match_count !== 5'(mc_e)) begin
                errors++;
                $display("FAIL %s match_count cyc%0d got %0d exp %0d", name, j, match_count, mc_e);
            end
            // Once LOAD has happened, scramble the inputs: the scan must not care.
            if (j == 1) begin
                data_in = 16'($urandom);
                len     = 5'($urandom);
                pattern = 4'($urandom);
            end
            if (poke_start && eff >= 4) begin
                if (j == 2) start = 1'b1;
                if (j == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        prev_mc = hits_upto(h, eff);
        if (exp_cnt >= 0) begin
            checks++;
            if (match_count !== 5'(exp_cnt)) begin
                errors++;
                $display("FAIL %s final count got %0d exp %0d", name, match_count, exp_cnt);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; data_in = '0; len = '0; pattern = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || z !== 1'b0 || match_count !== 5'd0) begin
            errors++;
            $display("FAIL reset outputs busy/done/z/mc got %b/%b/%b/%0d exp 0/0/0/0",
                     busy, done, z, match_count);
        end
        @(negedge clk);
        reset = 1'b0;
        prev_mc = 0;
    endtask

    task automatic test_fixed_vectors();
        run_scan(16'h6666, 5'd16, 4'b0110, 1'b0, 4, "v6666");
        run_scan(16'h6C00, 5'd7, 4'b0110, 1'b0, OVERLAP ? 2 : 1, "v6C00");
        run_scan(16'hFFFF, 5'd16, 4'b1111, 1'b0, OVERLAP ? 13 : 4, "vFFFF");
    endtask

    task automatic test_len_zero();
        run_scan(16'hFFFF, 5'd0, 4'b1111, 1'b0, 0, "len0");
    endtask

    task automatic test_len_clamp();
        run_scan(16'h6666, 5'd31, 4'b0110, 1'b0, 4, "len31");
    endtask

    task automatic test_start_ignored();
        run_scan(16'h6666, 5'd16, 4'b0110, 1'b1, 4, "poke");
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        start = 1'b1; data_in = 16'h6666; len = 5'd16; pattern = 4'b0110;
        @(posedge clk); #1;
        start = 1'b0;
        // After five more edges the first match's z pulse is showing.
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (z !== 1'b1 || match_count !== 5'd1) begin
            errors++;
            $display("FAIL midscan pre-reset z/mc got %b/%0d exp 1/1", z, match_count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || z !== 1'b0 || match_count !== 5'd0) begin
            errors++;
            $display("FAIL midscan async reset busy/done/z/mc got %b/%b/%b/%0d exp 0/0/0/0",
                     busy, done, z, match_count);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midscan held reset busy/done got %b/%b exp 0/0", busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        prev_mc = 0;
        // First start after reset must be taken straight away.
        run_scan(16'h6C00, 5'd7, 4'b0110, 1'b0, OVERLAP ? 2 : 1, "after_rst");
    endtask

    task automatic test_random();
        logic [3:0] p;
        logic [15:0] d;
        for (int i = 0; i < 30; i++) begin
            p = 4'($urandom);
            // Half the words are built from a repeated pattern to force hits.
            d = ($urandom_range(0, 1) == 1) ? {4{p}} ^ 16'($urandom_range(0, 3)) : 16'($urandom);
            run_scan(d, 5'($urandom_range(0, 20)), p, bit'($urandom_range(0, 1)), -1, "rand");
        end
    endtask

    task automatic test_back_to_back();
        run_scan(16'hF0F0, 5'd16, 4'b1111, 1'b0, -1, "b2b_a");
        run_scan(16'h3333, 5'd12, 4'b0011, 1'b0, -1, "b2b_b");
        run_scan(16'hAAAA, 5'd5, 4'b1010, 1'b0, -1, "b2b_c");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_mc = 0;
        test_reset();
        test_fixed_vectors();
        test_len_zero();
        test_len_clamp();
        test_start_ignored();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the parallel data word width in bits.
REQ-002 Parameter PLEN, default 4, SHALL set the pattern length in bits.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit, SHALL request one scan; it is sampled only in IDLE.
REQ-006 Port data_in, input, WIDTH bits, SHALL carry the word to scan, MSB-aligned, shifted out MSB first.
REQ-007 Port len, input, 5 bits, SHALL give the number of bits to scan (0..WIDTH).
REQ-008 Port pattern, input, PLEN bits, SHALL give the pattern to detect; pattern[PLEN-1] is the oldest bit.
REQ-009 Port busy, output, 1 bit, SHALL be high in LOAD and SHIFT.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle pulse in DONE.
REQ-011 Port z, output, 1 bit, SHALL be a registered one-cycle pulse per detected match.
REQ-012 Port match_count, output, 5 bits, SHALL hold the number of matches in the current or last scan.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE, encoded in a 2-bit register.
REQ-014 IDLE with start=1 SHALL go to LOAD; IDLE with start=0 SHALL stay in IDLE.
REQ-015 LOAD SHALL latch data_in, pattern and min(len,WIDTH), clear the window, fill counter, bit counter and match_count, then go to SHIFT, or to DONE if the latched len is 0.
REQ-016 SHIFT SHALL consume one bit per cycle: window <= {window[PLEN-2:0], bit}; fill saturates at PLEN.
REQ-017 SHIFT SHALL go to DONE on the cycle its latched len-th bit is consumed; DONE SHALL go to IDLE after one cycle.
REQ-018 A match SHALL be the updated window equal to the latched pattern with fill = PLEN.
REQ-019 On a match, z SHALL be high in the cycle after the matching bit is consumed, and match_count SHALL increment in the same cycle.
REQ-020 match_count SHALL saturate at 31 and SHALL hold its value through IDLE until the next LOAD.
REQ-021 start asserted while busy or done is high SHALL be ignored, with no queuing.
REQ-022 Latency: a start sampled at edge N SHALL give LOAD at N+1, SHIFT over N+2..N+len+1, and DONE at N+len+2.
REQ-023 Changes to data_in, len or pattern after LOAD SHALL NOT affect a scan in progress.

Reset
REQ-024 reset SHALL immediately force IDLE and clear busy, done, z and match_count to 0, along with the window, fill and counters, even in the middle of a scan.
REQ-025 After reset deasserts, the first start SHALL be honoured on the next rising edge.

Configuration
REQ-026 Macro SEQ_DET_CTRL_OVERLAP_EN, when defined, SHALL count overlapping matches, leaving window and fill unchanged after a match.
REQ-027 Without SEQ_DET_CTRL_OVERLAP_EN, a match SHALL clear the fill counter, so the next match needs PLEN new bits (non-overlapping).

Verification
REQ-028 pattern=4'b0110, data_in=16'h6666, len=16 -> 4 z pulses, match_count=4, done at start+18 cycles, in both macro settings.
REQ-029 pattern=4'b0110, data_in=16'h6C00, len=7 -> match_count=2 with the macro defined, 1 without.
REQ-030 pattern=4'b1111, data_in=16'hFFFF, len=16 -> match_count=13 with the macro defined, 4 without.
REQ-031 len=0 -> busy high for one cycle (LOAD), done pulse at start+2, match_count=0, z never high.
REQ-032 start pulsed during SHIFT -> ignored and the scan result is unchanged; reset asserted mid-SHIFT -> busy, z and match_count are 0 immediately and the state is IDLE.
